duart_tx_scheduler: RTL and testbench
=====================================

DUART_TX_SCHEDULER -- requirements
Module: duart_tx_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: TX byte FIFO depth, power of two.
REQ-002 SHALL have parameter POLL_GAP, default 2: number of clken cycles idle after a THR write before the next poll.
REQ-003 SHALL have parameter TXRDY_BIT, default 2: bit of DUART status register (addr 1) meaning channel A TxRDY.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 clken  in  1  bus access strobe; DUART accesses take effect only on clk edges with clken=1.
REQ-007 cpu_enable / cpu_we / cpu_addr / cpu_di  in  1/1/4/8  CPU register access request to the DUART.
REQ-008 cpu_do  out  8  read data to CPU, equal to duart_do combinationally.
REQ-009 fifo_wr / fifo_data  in  1/8  push one byte into the TX FIFO per clk with fifo_wr=1 (not clken-qualified).
REQ-010 fifo_full / fifo_empty  out  1/1  FIFO status, registered.
REQ-011 fifo_count  out  log2(FIFO_DEPTH)+1  bytes held, registered.
REQ-012 overflow  out  1  sticky; set by push while full.
REQ-013 duart_enable / duart_we / duart_addr / duart_di  out  1/1/4/8  multiplexed DUART register bus.
REQ-014 duart_do  in  8  DUART read data, combinational on duart_addr.

Function
REQ-015 SHALL give the CPU absolute priority: when cpu_enable=1, duart_* outputs equal cpu_* inputs combinationally and the engine issues no access that cycle.
REQ-016 SHALL, when cpu_enable=0 and the engine is not granted, drive duart_enable=0, duart_we=0, duart_addr=0, duart_di=0.
REQ-017 SHALL implement engine states IDLE, POLL, WRITE, GAP, state register updated every clk.
REQ-018 IDLE: move to POLL on the next clk when fifo_empty=0; otherwise stay.
REQ-019 POLL: granted when clken=1 and cpu_enable=0; drives duart_enable=1, duart_we=0, duart_addr=1; samples duart_do[TXRDY_BIT] on the same edge; 1 -> WRITE, 0 -> stay in POLL.
REQ-020 WRITE: granted when clken=1 and cpu_enable=0; drives duart_enable=1, duart_we=1, duart_addr=3, duart_di=FIFO head; pops FIFO on that edge; -> GAP with gap counter loaded to POLL_GAP.
REQ-021 GAP: decrement counter on each clken cycle; at zero -> POLL if FIFO non-empty, else IDLE.
REQ-022 SHALL stall any engine state whose access is pre-empted by the CPU (cpu_enable=1 on a clken cycle); retry on the next clken cycle with no state change.
REQ-023 SHALL never issue the engine's THR write unless the immediately preceding engine access was a POLL returning TxRDY=1.
REQ-024 FIFO SHALL be first-in first-out, with head stable from the POLL sample to the WRITE pop.
REQ-025 Push while full SHALL be discarded, set overflow, and leave the FIFO unchanged.
REQ-026 Simultaneous push and pop: when not full before the edge, both take effect and fifo_count is unchanged; when full, the pop is taken, the push is discarded, and overflow is set.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL span 0..FIFO_DEPTH.
REQ-028 Minimum latency, push into empty FIFO at edge N with clken always 1 and no CPU traffic: POLL access at edge N+2, THR write at edge N+3.

Reset
REQ-029 reset=1 SHALL force: state IDLE, pointers and fifo_count 0, fifo_empty=1, fifo_full=0, overflow=0, gap counter 0.
REQ-030 Reset mid-operation SHALL discard all queued bytes, including a byte polled but not yet written; no DUART write SHALL issue on the reset edge.
REQ-031 During reset, CPU pass-through (REQ-015) SHALL remain active.

Verification
REQ-032 Push 0x41,0x42 with clken=1, TxRDY=1 -> writes addr 3 with 0x41 then 0x42, in order, each preceded by an addr-1 read and separated by POLL_GAP idle clken cycles.
REQ-033 TxRDY held 0 for 10 clken cycles with 1 byte queued -> 10 consecutive addr-1 polls and no write; after TxRDY=1, exactly one write on the next clken.
REQ-034 cpu_enable=1, addr 5, data 0x08 on the engine's WRITE cycle -> DUART sees the CPU write; the engine write follows on the next clken cycle with unchanged data.
REQ-035 Push 17 bytes into a 16-deep FIFO with the engine blocked -> fifo_full=1, fifo_count=16, overflow=1; the 17th byte is never transmitted.
REQ-036 Push 0xAA, 0xBB, then reset asserted in WRITE state -> no addr-3 write, fifo_count=0, state IDLE, overflow=0.
REQ-037 clken pulsed once per 4 clk -> all engine accesses coincide with clken=1, and duart_enable=0 on all other cycles absent CPU traffic.

Source files
------------

// File: rtl/duart_tx_scheduler.sv
// Drains a byte FIFO into a DUART channel A transmitter: polls TxRDY, then writes THR,
// sharing the DUART register bus with a CPU that always wins arbitration.
module duart_tx_scheduler #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned POLL_GAP   = 2,
  parameter int unsigned TXRDY_BIT  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clken,
  input  logic                          cpu_enable,
  input  logic                          cpu_we,
  input  logic [3:0]                    cpu_addr,
  input  logic [7:0]                    cpu_di,
  output logic [7:0]                    cpu_do,
  input  logic                          fifo_wr,
  input  logic [7:0]                    fifo_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          duart_enable,
  output logic                          duart_we,
  output logic [3:0]                    duart_addr,
  output logic [7:0]                    duart_di,
  input  logic [7:0]                    duart_do
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned GW = $clog2(POLL_GAP + 2);

  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [GW-1:0] GapOne  = GW'(1);
  localparam logic [GW-1:0] GapLoad = GW'(POLL_GAP);

  localparam logic [3:0] AddrStatus = 4'd1;
  localparam logic [3:0] AddrThr    = 4'd3;

  typedef enum logic [1:0] {StIdle, StPoll, StWrite, StGap} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;

  logic            grant, push, pop;
  logic            eng_en, eng_we;
  logic [3:0]      eng_addr;
  logic [7:0]      eng_di;

  // The engine may only touch the bus on a clken cycle the CPU leaves free; never on reset.
  assign grant = clken & ~cpu_enable & ~reset;

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    pop      = 1'b0;
    eng_en   = 1'b0;
    eng_we   = 1'b0;
    eng_addr = '0;
    eng_di   = '0;
    case (state_q)
      StIdle: begin
        if (!empty_q) state_d = StPoll;
      end
      StPoll: begin
        if (grant) begin
          eng_en   = 1'b1;
          eng_addr = AddrStatus;
          if (duart_do[TXRDY_BIT]) state_d = StWrite;
        end
      end
      StWrite: begin
        if (grant) begin
          eng_en   = 1'b1;
          eng_we   = 1'b1;
          eng_addr = AddrThr;
          eng_di   = mem_q[rd_ptr_q];
          pop      = 1'b1;
          gap_d    = GapLoad;
          state_d  = StGap;
        end
      end
      StGap: begin
        if (clken) begin
          if (gap_q <= GapOne) begin
            gap_d   = '0;
            state_d = empty_q ? StIdle : StPoll;
          end else begin
            gap_d = gap_q - GapOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A push while full is dropped even if the same edge pops.
  always_comb begin
    push     = fifo_wr & ~full_q & ~reset;
    ovf_d    = ovf_q | (fifo_wr & full_q);
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntFull);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_data;
  end

  always_comb begin
    if (cpu_enable) begin
      duart_enable = 1'b1;
      duart_we     = cpu_we;
      duart_addr   = cpu_addr;
      duart_di     = cpu_di;
    end else begin
      duart_enable = eng_en;
      duart_we     = eng_we;
      duart_addr   = eng_addr;
      duart_di     = eng_di;
    end
  end

  assign cpu_do     = duart_do;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_duart_tx_scheduler.sv
// Bench for duart_tx_scheduler: directed scenarios plus a randomized run, all checked
// cycle by cycle against a queue-based model of the transmit scheduler.
module tb_duart_tx_scheduler;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned POLL_GAP   = 2;
  localparam int unsigned TXRDY_BIT  = 2;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int          GapIdle    = (POLL_GAP > 0) ? POLL_GAP : 1;

  logic          clk = 1'b0;
  logic          reset, clken, cpu_enable, cpu_we;
  logic [3:0]    cpu_addr;
  logic [7:0]    cpu_di, cpu_do;
  logic          fifo_wr;
  logic [7:0]    fifo_data;
  logic          fifo_full, fifo_empty, overflow;
  logic [CW-1:0] fifo_count;
  logic          duart_enable, duart_we;
  logic [3:0]    duart_addr;
  logic [7:0]    duart_di, duart_do;
  logic          txrdy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  bit div_mode = 1'b0;

  logic [7:0] wlog[$];
  int         wcyc[$];
  int         pcyc[$];

  // Model state: queued bytes, sticky overflow, and where the engine is in its cycle.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_active = 1'b0;
  bit         m_rdy = 1'b0;
  int         m_gap = 0;
  int         pre;
  bit         m_grant;

  logic       e_en, e_we;
  logic [3:0] e_addr;
  logic [7:0] e_di;

  always #5 clk = ~clk;

  assign duart_do = (duart_addr == 4'd1) ? (8'h81 | (8'(txrdy) << TXRDY_BIT)) : 8'h5A;

  duart_tx_scheduler #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .POLL_GAP   (POLL_GAP),
    .TXRDY_BIT  (TXRDY_BIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clken        (clken),
    .cpu_enable   (cpu_enable),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_di       (cpu_di),
    .cpu_do       (cpu_do),
    .fifo_wr      (fifo_wr),
    .fifo_data    (fifo_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .duart_enable (duart_enable),
    .duart_we     (duart_we),
    .duart_addr   (duart_addr),
    .duart_di     (duart_di),
    .duart_do     (duart_do)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge bookkeeping: log engine accesses actually seen on the bus, then advance the model.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!cpu_enable && duart_enable) begin
      if (duart_we && duart_addr == 4'd3) begin
        wlog.push_back(duart_di);
        wcyc.push_back(cyc);
      end else if (!duart_we && duart_addr == 4'd1) begin
        pcyc.push_back(cyc);
      end
    end
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_active = 1'b0;
      m_rdy = 1'b0;
      m_gap = 0;
    end else begin
      pre = q.size();
      m_grant = clken && !cpu_enable && m_active && (m_gap == 0);
      if (!m_active) begin
        m_active = (pre != 0);
      end else if (m_gap > 0) begin
        if (clken) begin
          m_gap = m_gap - 1;
          if (m_gap == 0) m_active = (pre != 0);
        end
      end else if (m_grant) begin
        if (m_rdy) begin
          void'(q.pop_front());
          m_rdy = 1'b0;
          m_gap = GapIdle;
        end else begin
          m_rdy = txrdy;
        end
      end
      if (fifo_wr) begin
        if (pre < FIFO_DEPTH) q.push_back(fifo_data);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      e_en = 1'b0; e_we = 1'b0; e_addr = 4'd0; e_di = 8'd0;
      if (cpu_enable) begin
        e_en = 1'b1; e_we = cpu_we; e_addr = cpu_addr; e_di = cpu_di;
      end else if (!reset && clken && m_active && m_gap == 0) begin
        e_en = 1'b1;
        if (m_rdy) begin
          e_we = 1'b1; e_addr = 4'd3; e_di = (q.size() > 0) ? q[0] : 8'h00;
        end else begin
          e_addr = 4'd1;
        end
      end
      check("duart_enable", duart_enable, e_en);
      check("duart_we", duart_we, e_we);
      check("duart_addr", duart_addr, e_addr);
      check("duart_di", duart_di, e_di);
      check("cpu_do", cpu_do, duart_do);
      check("fifo_count", fifo_count, q.size());
      check("fifo_full", fifo_full, q.size() == FIFO_DEPTH);
      check("fifo_empty", fifo_empty, q.size() == 0);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (div_mode) clken = (cyc % 4 == 0);
    end
  endtask

  task automatic idle_inputs();
    fifo_wr = 1'b0; cpu_enable = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_di = 8'd0;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_wr = 1'b1; fifo_data = d;
    step();
    fifo_wr = 1'b0;
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); pcyc.delete();
  endtask

  task automatic wait_polls(input int n, input int budget, input string name);
    int k = 0;
    while (pcyc.size() < n && k < budget) begin
      step();
      k++;
    end
    vectors++;
    if (pcyc.size() < n) begin
      miscompares++;
      $display("FAIL %s: timed out with %0d polls, needed %0d", name, pcyc.size(), n);
    end
  endtask

  int n0;
  int bad;

  initial begin
    reset = 1'b1; clken = 1'b1; txrdy = 1'b1; fifo_data = 8'd0;
    idle_inputs();
    step(2);
    chk_on = 1'b1;
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_bus_idle", duart_enable, 0);
    cpu_enable = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h7; cpu_di = 8'h3C;
    #1;
    check("rst_passthru_addr", duart_addr, 4'h7);
    check("rst_passthru_di", duart_di, 8'h3C);
    step();
    idle_inputs();
    reset = 1'b0;
    step(2);

    // Minimum latency from a push into an empty FIFO.
    clear_logs();
    push(8'h11);
    n0 = cyc;
    step(4);
    check("lat_poll_edge", (pcyc.size() > 0) ? pcyc[0] : -1, n0 + 2);
    check("lat_write_edge", (wcyc.size() > 0) ? wcyc[0] : -1, n0 + 3);
    check("lat_write_data", (wlog.size() > 0) ? wlog[0] : 8'hFF, 8'h11);
    step(6);

    // Two bytes go out in order, each behind its own poll, spaced by the gap.
    clear_logs();
    push(8'h41);
    push(8'h42);
    step(20);
    check("order_nwrites", wlog.size(), 2);
    check("order_npolls", pcyc.size(), 2);
    if (wlog.size() == 2 && pcyc.size() == 2) begin
      check("order_first", wlog[0], 8'h41);
      check("order_second", wlog[1], 8'h42);
      check("order_spacing", wcyc[1] - wcyc[0], POLL_GAP + 2);
      check("order_poll_before", pcyc[1], wcyc[1] - 1);
    end

    // TxRDY held low: repeated polls, no write, then exactly one write once it rises.
    clear_logs();
    txrdy = 1'b0;
    push(8'h33);
    wait_polls(10, 40, "busy_polls");
    check("busy_nowrite", wlog.size(), 0);
    check("busy_consecutive", (pcyc.size() >= 10) ? pcyc[9] - pcyc[0] : -1, 9);
    txrdy = 1'b1;
    step(3);
    check("busy_one_write", wlog.size(), 1);
    check("busy_write_after_poll", (wcyc.size() > 0 && pcyc.size() > 10) ? wcyc[0] - pcyc[10] : -1, 1);
    step(8);

    // CPU pre-empts the engine's THR write; the engine retries next clken.
    clear_logs();
    push(8'h77);
    wait_polls(1, 20, "preempt_poll");
    cpu_enable = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd5; cpu_di = 8'h08;
    #1;
    check("preempt_cpu_addr", duart_addr, 4'd5);
    check("preempt_cpu_di", duart_di, 8'h08);
    step();
    idle_inputs();
    check("preempt_no_engine_write", wlog.size(), 0);
    step(2);
    check("preempt_retry_data", (wlog.size() > 0) ? wlog[0] : 8'hFF, 8'h77);
    check("preempt_retry_edge", (wcyc.size() > 0 && pcyc.size() > 0) ? wcyc[0] - pcyc[0] : -1, 2);
    step(8);

    // Overfill a blocked FIFO; the extra byte must vanish.
    clear_logs();
    txrdy = 1'b0;
    for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
    check("ovf_full", fifo_full, 1);
    check("ovf_count", fifo_count, 16);
    check("ovf_flag", overflow, 1);
    txrdy = 1'b1;
    step(16 * (POLL_GAP + 2) + 10);
    check("ovf_drained", wlog.size(), 16);
    bad = 0;
    for (int i = 0; i < 16 && i < wlog.size(); i++) if (wlog[i] !== 8'hC0 + 8'(i)) bad++;
    check("ovf_drain_order", bad, 0);
    check("ovf_sticky", overflow, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ovf_reset_clears", overflow, 0);

    // Reset while the engine sits in WRITE drops everything, including the polled byte.
    clear_logs();
    push(8'hAA);
    push(8'hBB);
    wait_polls(1, 20, "rstw_poll");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstw_nowrite", wlog.size(), 0);
    check("rstw_count", fifo_count, 0);
    check("rstw_empty", fifo_empty, 1);
    check("rstw_overflow", overflow, 0);
    step(10);
    check("rstw_stays_idle", wlog.size() + pcyc.size(), 1);

    // clken once every 4 clk: every engine access lands on a clken edge.
    clear_logs();
    div_mode = 1'b1;
    push(8'h51);
    push(8'h52);
    push(8'h53);
    step(120);
    div_mode = 1'b0;
    clken = 1'b1;
    check("div_nwrites", wlog.size(), 3);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] !== 8'h51 + 8'(i)) bad++;
    foreach (wcyc[i]) if (wcyc[i] % 4 != 1) bad++;
    foreach (pcyc[i]) if (pcyc[i] % 4 != 1) bad++;
    check("div_alignment", bad, 0);
    step(4);

    // Randomized traffic; the per-cycle compare does the work here.
    for (int i = 0; i < 4000; i++) begin
      clken      = ($urandom_range(0, 3) != 0);
      cpu_enable = ($urandom_range(0, 9) == 0);
      cpu_we     = 1'($urandom);
      cpu_addr   = 4'($urandom);
      cpu_di     = 8'($urandom);
      fifo_wr    = ($urandom_range(0, (i < 2000) ? 2 : 6) == 0);
      fifo_data  = 8'($urandom);
      txrdy      = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 499) == 0);
      step();
    end
    idle_inputs();
    reset = 1'b0;
    clken = 1'b1;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
